strobe_rx: RTL
==============

# strobe_rx

Multi-channel receive side of the toggle-flag strobe crossing. Each of CHANNELS senders presents a toggle flag and a held data word from a foreign clock domain. This block synchronises each flag into `clk`, captures the word into a small per-channel FIFO and returns a toggle acknowledge. A round-robin arbiter merges all channels into one valid/ready stream. It sits at the boundary between the USB/SPI clock domains and the bootloader core logic, and replaces ad-hoc single-bit strobe crossings.

## Interface
- CHANNELS, 4: number of independent strobe channels (1..16).
- WIDTH, 8: data bits per channel.
- DELAY, 2: synchroniser flops per flag (>= 2).
- DEPTH, 2: per-channel FIFO entries (power of 2, >= 2).
- clk  in  1  sole clock; all registers on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- flag_in  in  CHANNELS  per-channel toggle flags from the foreign domain (asynchronous).
- data_in  in  CHANNELS*WIDTH  channel c at bits [c*WIDTH +: WIDTH]; the sender holds it stable from its flag toggle until ack_out toggles.
- ack_out  out  CHANNELS  per-channel toggle acknowledge (the seen flag).
- out_valid  out  1  output word available.
- out_ready  in  1  consumer accepts the word when high with out_valid.
- out_channel  out  clog2(CHANNELS) (min 1)  source channel of out_data.
- out_data  out  WIDTH  captured word.
- overflow  out  CHANNELS  sticky drop indicator. Used only without STROBE_RX_ACK_EN.

## Operation
- Per channel:
  - Synchroniser sync[DELAY-1:0] shifts in flag_in.
  - seen register holds the last serviced flag value.
  - pending = sync[DELAY-1] != seen.
- Capture: when pending and the FIFO can accept (not full, or full with a same-cycle pop):
  - push data_in slice;
  - seen <= sync[DELAY-1].
- ack_out[c] = seen[c] (registered).
- FIFO: supports simultaneous push and pop. When full, a push is accepted only with a same-cycle pop. Empty with a push: data is visible next cycle.
- Output stage is a registered holding slot (out_valid, out_channel, out_data). It loads when empty or when the current word is accepted (out_valid && out_ready).
- Arbiter selects among non-empty FIFOs in round-robin order:
  - priority starts at the channel after the last grant;
  - reset pointer gives channel 0 first priority;
  - the pointer advances only on a load.
- out_valid holds, and out_data/out_channel stay stable, until accepted.
- Reset (asynchronous, any time):
  - sync, seen, FIFOs, pointer, output slot and overflow all go to 0;
  - in-flight events are lost;
  - senders must be reset together, with flag 0 at reset.

## Timing
- Flag toggle sampled at edge k:
  - sync[DELAY-1] updates at edge k+DELAY-1;
  - push and ack_out toggle at edge k+DELAY (FIFO not full);
  - out_valid rises after edge k+DELAY+1 (output slot empty, no contention).
- Throughput: one word per cycle across all channels with out_ready held high.
- Per-channel rate: one event per sender round trip. The sender must not toggle again before it sees ack_out toggle.
- Back-to-back toggles faster than DELAY cycles are outside protocol. Behaviour is undefined but must not deadlock.

## Configuration
- STROBE_RX_ACK_EN defined:
  - full toggle handshake as above;
  - when the FIFO is full, capture and ack are withheld until space frees, so no event is lost;
  - overflow is tied to 0.
- STROBE_RX_ACK_EN undefined (fire-and-forget senders):
  - a pending event on a full FIFO with no same-cycle pop is dropped: seen updates, no push, overflow[c] set sticky until reset;
  - ack_out is still driven from seen.

## Structure
- Package strobe_pkg: clog2-based CHANNEL_W width function, reset constants, and the channel-index typedef.
- Sub-module strobe_rx_fifo (WIDTH, DEPTH) holds the per-channel FIFO storage, pointers, full and empty; it is instantiated CHANNELS times.
- Synchronisers, the arbiter and the output slot stay in strobe_rx.

## Test plan
Default parameters: CHANNELS=4, WIDTH=8, DELAY=2, DEPTH=2.
- Reset: reset_n=0 -> all outputs 0 immediately. After release with idle flags, out_valid stays 0 for 100 cycles.
- Single event: data_in ch2=0xA5, flag_in[2] toggled before edge k -> ack_out[2] toggles at edge k+2; out_valid=1 after edge k+3 with out_channel=2, out_data=0xA5; drops one edge after out_ready=1.
- Round robin: ch0, ch1 and ch3 fire in the same cycle with out_ready=1 -> consecutive words from ch0, ch1, ch3. Then ch0 and ch3 fire together -> ch0 first, then ch3.
- Backpressure with STROBE_RX_ACK_EN, out_ready=0: ch1 sends 0x11..0x44, waiting for each ack -> exactly 3 ack toggles. Raise out_ready -> 0x11, 0x22, 0x33, 0x44 delivered in order, and the 4th ack toggles.
- Same stimulus without STROBE_RX_ACK_EN and no ack wait -> 0x44 dropped, overflow[1]=1, only 0x11..0x33 delivered.
- Reset mid-operation with FIFO and output slot full -> outputs 0 asynchronously; after release no stale word appears.

Source files
------------

// File: rtl/strobe_pkg.sv
// Shared types and constants for the toggle-flag strobe receiver.
package strobe_pkg;

  localparam int unsigned MAX_CHANNELS = 16;
  localparam logic        FLAG_RESET   = 1'b0;
  localparam logic        VALID_RESET  = 1'b0;

  typedef logic [$clog2(MAX_CHANNELS)-1:0] chan_t;

  // Width of a channel index; a single channel still needs one bit.
  function automatic int unsigned CHANNEL_W(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/strobe_rx_fifo.sv
// Per-channel receive FIFO: power-of-two depth, simultaneous push/pop,
// a push while full is taken only together with a pop.
module strobe_rx_fifo
  import strobe_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wrPtr_q, wrPtr_d;
  logic [AW:0]      rdPtr_q, rdPtr_d;
  logic             doPush, doPop;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign empty_o    = (wrPtr_q == rdPtr_q);
  assign full_o     = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                      (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign pop_data_o = mem_q[rdPtr_q[AW-1:0]];

  always_comb begin
    doPush  = push_i && (!full_o || pop_i);
    doPop   = pop_i && !empty_o;
    wrPtr_d = doPush ? wrPtr_q + 1'b1 : wrPtr_q;
    rdPtr_d = doPop  ? rdPtr_q + 1'b1 : rdPtr_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      if (doPush) mem_q[wrPtr_q[AW-1:0]] <= push_data_i;
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

endmodule

// File: rtl/strobe_rx.sv
// strobe_rx: multi-channel toggle-flag receiver merging all channels into one
// valid/ready stream. Macro STROBE_RX_ACK_EN withholds ack on a full FIFO instead of dropping.
module strobe_rx
  import strobe_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DELAY    = 2,
  parameter int unsigned DEPTH    = 2
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [CHANNELS-1:0]            flag_in,
  input  logic [CHANNELS*WIDTH-1:0]      data_in,
  output logic [CHANNELS-1:0]            ack_out,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [CHANNEL_W(CHANNELS)-1:0] out_channel,
  output logic [WIDTH-1:0]               out_data,
  output logic [CHANNELS-1:0]            overflow
);

  localparam int unsigned CW = CHANNEL_W(CHANNELS);

  logic [DELAY-1:0]    sync_q [CHANNELS];
  logic [CHANNELS-1:0] seen_q, seen_d;
  logic [CHANNELS-1:0] syncFlag, pending, canAccept, push, pop, full, empty;
  logic [WIDTH-1:0]    fifoData [CHANNELS];

  chan_t            ptr_q, ptr_d, grant;
  logic             anyReq, load;
  logic [WIDTH-1:0] selData;
  logic             outValid_q, outValid_d;
  logic [CW-1:0]    outChannel_q, outChannel_d;
  logic [WIDTH-1:0] outData_q, outData_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < CHANNELS; c++) sync_q[c] <= '0;
      seen_q <= {CHANNELS{FLAG_RESET}};
    end else begin
      for (int c = 0; c < CHANNELS; c++) sync_q[c] <= {sync_q[c][DELAY-2:0], flag_in[c]};
      seen_q <= seen_d;
    end
  end

  always_comb begin
    syncFlag = '0;
    for (int c = 0; c < CHANNELS; c++) syncFlag[c] = sync_q[c][DELAY-1];
    pending   = syncFlag ^ seen_q;
    canAccept = ~full | pop;
    push      = pending & canAccept;
  end

`ifdef STROBE_RX_ACK_EN
  // A blocked event leaves seen untouched, so it stays pending until space frees.
  assign seen_d   = seen_q ^ push;
  assign overflow = '0;
`else
  logic [CHANNELS-1:0] overflow_q;

  // Every pending event is consumed; those that found no room are dropped and flagged.
  assign seen_d   = syncFlag;
  assign overflow = overflow_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) overflow_q <= '0;
    else          overflow_q <= overflow_q | (pending & ~canAccept);
  end
`endif

  for (genvar c = 0; c < CHANNELS; c++) begin : g_fifo
    strobe_rx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk         (clk),
      .reset_n     (reset_n),
      .push_i      (push[c]),
      .push_data_i (data_in[c*WIDTH +: WIDTH]),
      .pop_i       (pop[c]),
      .pop_data_o  (fifoData[c]),
      .full_o      (full[c]),
      .empty_o     (empty[c])
    );
  end

  // Round robin: scan outward from the pointer, first non-empty FIFO wins.
  always_comb begin
    anyReq  = 1'b0;
    grant   = '0;
    selData = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      for (int j = 0; j < CHANNELS; j++) begin
        if (!anyReq && !empty[j] && (j == (int'(ptr_q) + i) % CHANNELS)) begin
          anyReq  = 1'b1;
          grant   = chan_t'(j);
          selData = fifoData[j];
        end
      end
    end
  end

  always_comb begin
    load         = !outValid_q || out_ready;
    pop          = '0;
    outValid_d   = outValid_q;
    outChannel_d = outChannel_q;
    outData_d    = outData_q;
    ptr_d        = ptr_q;
    if (load) begin
      outValid_d = anyReq;
      if (anyReq) begin
        for (int j = 0; j < CHANNELS; j++) pop[j] = (int'(grant) == j);
        outChannel_d = grant[CW-1:0];
        outData_d    = selData;
        ptr_d        = chan_t'((int'(grant) + 1) % CHANNELS);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      outValid_q   <= VALID_RESET;
      outChannel_q <= '0;
      outData_q    <= '0;
      ptr_q        <= '0;
    end else begin
      outValid_q   <= outValid_d;
      outChannel_q <= outChannel_d;
      outData_q    <= outData_d;
      ptr_q        <= ptr_d;
    end
  end

  assign ack_out     = seen_q;
  assign out_valid   = outValid_q;
  assign out_channel = outChannel_q;
  assign out_data    = outData_q;

endmodule
